// File: rtl/ipsxe_floating_point_fma_arbiter_v1_0_pkg.sv
// Shared definitions for the FMA wrapper family: operand geometry, tag width
// and field-offset helpers for sign/exponent/mantissa slicing.
package ipsxe_floating_point_fma_arbiter_v1_0_pkg;

  localparam int unsigned DEF_EXP_WIDTH = 8;
  localparam int unsigned DEF_MAN_WIDTH = 23;
  localparam int unsigned DEF_N_REQ     = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int unsigned man_lsb(input int unsigned exp_w, input int unsigned man_w);
    return 0;
  endfunction

  function automatic int unsigned exp_lsb(input int unsigned exp_w, input int unsigned man_w);
    return man_w;
  endfunction

  function automatic int unsigned sign_pos(input int unsigned exp_w, input int unsigned man_w);
    return exp_w + man_w;
  endfunction

  localparam int unsigned WIDTH = fp_width(DEF_EXP_WIDTH, DEF_MAN_WIDTH);
  localparam int unsigned ID_W  = clog2(DEF_N_REQ);

endpackage

// File: rtl/ipsxe_floating_point_fma_arbiter_v1_0_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, searching from the
// pointer upward with wrap; pointer advances past each winner.
module ipsxe_floating_point_rr_arbiter_v1_0
  import ipsxe_floating_point_fma_arbiter_v1_0_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned ID_W = clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  localparam int unsigned SW = ID_W + 1;

  logic [ID_W-1:0] ptr;
  logic [SW-1:0]   sum;
  logic [ID_W-1:0] cand;
  logic            found;

  // Scan ptr, ptr+1, ... with modular wrap; first requester found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    if (en) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        sum = {1'b0, ptr} + SW'(i);
        if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
        cand = sum[ID_W-1:0];
        if (!found && req[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_fma_arbiter_v1_0.sv
// Shares one fixed-latency FMA among N_REQ requesters: RR issue, shadow tag
// pipe, result steering. Optional tag compare under FMA_ARB_TAG_CHECK_EN.
module ipsxe_floating_point_fma_arbiter_v1_0
  import ipsxe_floating_point_fma_arbiter_v1_0_pkg::*;
#(
  parameter int unsigned EXP_WIDTH   = 8,
  parameter int unsigned MAN_WIDTH   = 23,
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned FMA_LATENCY = 8,
  localparam int unsigned WIDTH      = fp_width(EXP_WIDTH, MAN_WIDTH),
  localparam int unsigned ID_W       = clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_aclken,
  input  logic [N_REQ-1:0]       i_req_valid,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic [N_REQ*WIDTH-1:0] i_req_a,
  input  logic [N_REQ*WIDTH-1:0] i_req_b,
  input  logic [N_REQ*WIDTH-1:0] i_req_c,
  output logic [WIDTH-1:0]       o_fma_a,
  output logic [WIDTH-1:0]       o_fma_b,
  output logic [WIDTH-1:0]       o_fma_c,
  output logic                   o_fma_valid,
  output logic [ID_W-1:0]        o_fma_user,
  input  logic [WIDTH-1:0]       i_fma_result,
  input  logic [ID_W-1:0]        i_fma_user,
  output logic [N_REQ-1:0]       o_res_valid,
  output logic [WIDTH-1:0]       o_res_data,
  output logic [ID_W-1:0]        o_res_id,
  output logic                   o_busy,
  output logic                   o_tag_err
);

  localparam int unsigned LAST = FMA_LATENCY - 1;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             transfer;
  logic [WIDTH-1:0] sel_a, sel_b, sel_c;

  logic [FMA_LATENCY-1:0] sh_valid;
  logic [ID_W-1:0]        sh_id [FMA_LATENCY];
  logic [N_REQ-1:0]       ret_onehot;

  ipsxe_floating_point_rr_arbiter_v1_0 #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .clk       (i_clk),
    .rst       (i_rst),
    .en        (i_aclken),
    .req       (i_req_valid),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign transfer    = |grant;
  assign o_req_ready = grant;

  // Grant is one-hot, so an AND-OR mux picks the winner's operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_a = sel_a | i_req_a[k*WIDTH +: WIDTH];
        sel_b = sel_b | i_req_b[k*WIDTH +: WIDTH];
        sel_c = sel_c | i_req_c[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fma_valid <= 1'b0;
      o_fma_a     <= '0;
      o_fma_b     <= '0;
      o_fma_c     <= '0;
      o_fma_user  <= '0;
    end else if (i_aclken) begin
      o_fma_valid <= transfer;
      if (transfer) begin
        o_fma_a    <= sel_a;
        o_fma_b    <= sel_b;
        o_fma_c    <= sel_c;
        o_fma_user <= grant_idx;
      end
    end
  end

  // Shadow pipe advances in lockstep with the FMA core's own clock enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_valid <= '0;
      for (int unsigned i = 0; i < FMA_LATENCY; i++) sh_id[i] <= '0;
    end else if (i_aclken) begin
      sh_valid[0] <= o_fma_valid;
      sh_id[0]    <= o_fma_user;
      for (int unsigned i = 1; i < FMA_LATENCY; i++) begin
        sh_valid[i] <= sh_valid[i-1];
        sh_id[i]    <= sh_id[i-1];
      end
    end
  end

  assign ret_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << sh_id[LAST];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_res_valid <= '0;
      o_res_data  <= '0;
      o_res_id    <= '0;
    end else if (i_aclken && sh_valid[LAST]) begin
      o_res_valid <= ret_onehot;
      o_res_data  <= i_fma_result;
      o_res_id    <= sh_id[LAST];
    end else begin
      o_res_valid <= '0;
    end
  end

  assign o_busy = o_fma_valid | (|sh_valid) | (|o_res_valid);

`ifdef FMA_ARB_TAG_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tag_err <= 1'b0;
    end else if (i_aclken && sh_valid[LAST] && (i_fma_user != sh_id[LAST])) begin
      o_tag_err <= 1'b1;
    end
  end
`else
  logic unused_fma_user;
  assign unused_fma_user = ^i_fma_user;
  assign o_tag_err       = 1'b0;
`endif

endmodule

// File: tb/tb_ipsxe_floating_point_fma_arbiter_v1_0.sv
// Directed bench for the FMA arbiter with a behavioural 8-stage a*b+c model.
module tb_ipsxe_floating_point_fma_arbiter_v1_0;

  localparam int unsigned L = 8;

`ifdef FMA_ARB_TAG_CHECK_EN
  localparam logic TAG_EN = 1'b1;
`else
  localparam logic TAG_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, aclken;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b, req_c;
  logic [31:0]  fma_a, fma_b, fma_c, fma_result;
  logic         fma_valid;
  logic [1:0]   fma_user, fma_user_ret;
  logic [3:0]   res_valid;
  logic [31:0]  res_data;
  logic [1:0]   res_id;
  logic         busy, tag_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ipsxe_floating_point_fma_arbiter_v1_0 #(
    .EXP_WIDTH   (8),
    .MAN_WIDTH   (23),
    .N_REQ       (4),
    .FMA_LATENCY (L)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_aclken     (aclken),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .i_req_c      (req_c),
    .o_fma_a      (fma_a),
    .o_fma_b      (fma_b),
    .o_fma_c      (fma_c),
    .o_fma_valid  (fma_valid),
    .o_fma_user   (fma_user),
    .i_fma_result (fma_result),
    .i_fma_user   (fma_user_ret),
    .o_res_valid  (res_valid),
    .o_res_data   (res_data),
    .o_res_id     (res_id),
    .o_busy       (busy),
    .o_tag_err    (tag_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester k default operands: a=(k+1).0, b=2.0, c=1.0 -> 3,5,7,9.
  logic [31:0] fl_in   [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] res_tab [4] = '{32'h40400000, 32'h40A00000, 32'h40E00000, 32'h41100000};

  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) return 0.0;
    d = {s[31], 11'({3'b000, s[30:23]}) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_fma(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
    return r2s(s2r(a) * s2r(b) + s2r(c));
  endfunction

  // FMA core model: fixed latency, shares aclken, not reset; can corrupt one tag.
  logic [31:0] m_res  [L];
  logic [1:0]  m_user [L];
  int issue_cnt  = 0;
  int corrupt_at = -1;

  assign fma_result   = m_res[L-1];
  assign fma_user_ret = m_user[L-1];

  always @(posedge clk) begin
    if (aclken) begin
      for (int i = L - 1; i > 0; i--) begin
        m_res[i]  <= m_res[i-1];
        m_user[i] <= m_user[i-1];
      end
      m_res[0]  <= fp_fma(fma_a, fma_b, fma_c);
      m_user[0] <= (fma_valid && issue_cnt == corrupt_at) ? ~fma_user : fma_user;
      if (fma_valid) issue_cnt <= issue_cnt + 1;
    end
  end

  typedef struct {
    int          cyc;
    logic [3:0]  oh;
    logic [1:0]  id;
    logic [31:0] data;
    logic        terr;
  } rec_t;
  rec_t q[$];

  always @(negedge clk) begin
    if (res_valid != 4'b0000)
      q.push_back('{cyc: cyc, oh: res_valid, id: res_id, data: res_data, terr: tag_err});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops();
    for (int k = 0; k < 4; k++) begin
      req_a[k*32 +: 32] = fl_in[k];
      req_b[k*32 +: 32] = 32'h40000000;
      req_c[k*32 +: 32] = 32'h3F800000;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 60 && busy; n++) step();
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic chk_rec(input string tag, input int base, input int idx, input logic [1:0] id,
                         input logic [31:0] data, input int cyc_e, input logic terr);
    int i;
    i = base + idx;
    if (i >= q.size()) begin
      checks++;
      errors++;
      $error("FAIL %s result %0d observed=none expected=id%0d", tag, idx, id);
    end else begin
      check({tag, "_onehot"}, 32'(q[i].oh), 32'(4'b0001 << id));
      check({tag, "_id"}, 32'(q[i].id), 32'(id));
      check({tag, "_data"}, q[i].data, data);
      check({tag, "_cycle"}, 32'(q[i].cyc), 32'(cyc_e));
      check({tag, "_tag_err"}, 32'(q[i].terr), 32'(terr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t0;
    rst       = 1'b1;
    aclken    = 1'b1;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    load_ops();
    step();
    step();

    check("rst_fma_valid", 32'(fma_valid), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_tag_err", 32'(tag_err), 32'd0);
    rst = 1'b0;
    step();

    // All four valid after reset: grants 0,1,2,3,0.
    base = q.size();
    t0 = cyc;
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      #1;
      check("prio_ready", 32'(req_ready), 32'(4'b0001 << (g % 4)));
      step();
      check("prio_fma_valid", 32'(fma_valid), 32'd1);
      check("prio_fma_user", 32'(fma_user), 32'(g % 4));
    end
    req_valid = 4'b0000;
    wait_idle("prio_idle");
    check("prio_count", 32'(q.size() - base), 32'd5);
    for (int g = 0; g < 5; g++)
      chk_rec("prio", base, g, 2'(g % 4), res_tab[g % 4], t0 + g + 10, 1'b0);

    // Single requester 2: 1.0*2.0+1.0 = 3.0.
    base = q.size();
    req_a[64 +: 32] = 32'h3F800000;
    req_b[64 +: 32] = 32'h40000000;
    req_c[64 +: 32] = 32'h3F800000;
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'b0100);
    t0 = cyc;
    step();
    req_valid = 4'b0000;
    wait_idle("single_idle");
    check("single_count", 32'(q.size() - base), 32'd1);
    chk_rec("single", base, 0, 2'd2, 32'h40400000, t0 + 10, 1'b0);
    load_ops();

    // Pointer wrap: grant 3, then with 0 and 3 pending, 0 wins first.
    base = q.size();
    t0 = cyc;
    req_valid = 4'b1000;
    #1;
    check("wrap_grant3", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'b1001;
    #1;
    check("wrap_grant0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b1000;
    #1;
    check("wrap_then3", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'b0000;
    wait_idle("wrap_idle");
    check("wrap_count", 32'(q.size() - base), 32'd3);
    chk_rec("wrap_r0", base, 0, 2'd3, res_tab[3], t0 + 10, 1'b0);
    chk_rec("wrap_r1", base, 1, 2'd0, res_tab[0], t0 + 11, 1'b0);
    chk_rec("wrap_r2", base, 2, 2'd3, res_tab[3], t0 + 12, 1'b0);

    // Clock-enable stall of 5 cycles starting while the first result is on the bus.
    base = q.size();
    t0 = cyc;
    req_valid = 4'b0111;
    step();
    step();
    step();
    req_valid = 4'b0000;
    for (int n = 0; n < 20 && cyc < t0 + 10; n++) step();
    check("stall_first_live", 32'(res_valid), 32'b0001);
    aclken = 1'b0;
    req_valid = 4'hF;
    #1;
    check("stall_ready", 32'(req_ready), 32'd0);
    step();
    check("stall_no_dup", 32'(res_valid), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    step();
    step();
    step();
    step();
    aclken = 1'b1;
    req_valid = 4'b0000;
    wait_idle("stall_idle");
    check("stall_count", 32'(q.size() - base), 32'd3);
    chk_rec("stall_r0", base, 0, 2'd0, res_tab[0], t0 + 10, 1'b0);
    chk_rec("stall_r1", base, 1, 2'd1, res_tab[1], t0 + 16, 1'b0);
    chk_rec("stall_r2", base, 2, 2'd2, res_tab[2], t0 + 17, 1'b0);

    // Reset with six operations in flight.
    req_valid = 4'hF;
    for (int n = 0; n < 6; n++) step();
    req_valid = 4'b0000;
    step();
    step();
    rst = 1'b1;
    step();
    check("mrst_fma_valid", 32'(fma_valid), 32'd0);
    check("mrst_fma_a", fma_a, 32'd0);
    check("mrst_fma_b", fma_b, 32'd0);
    check("mrst_fma_c", fma_c, 32'd0);
    check("mrst_fma_user", 32'(fma_user), 32'd0);
    check("mrst_res_valid", 32'(res_valid), 32'd0);
    check("mrst_res_data", res_data, 32'd0);
    check("mrst_res_id", 32'(res_id), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd0);
    check("mrst_tag_err", 32'(tag_err), 32'd0);
    rst = 1'b0;
    base = q.size();
    for (int n = 0; n < 20; n++) step();
    check("mrst_no_stale", 32'(q.size() - base), 32'd0);
    check("mrst_busy_after", 32'(busy), 32'd0);

    // Tag corruption on the third issue of this burst.
    base = q.size();
    t0 = cyc;
    corrupt_at = issue_cnt + 2;
    req_valid = 4'hF;
    for (int n = 0; n < 4; n++) step();
    req_valid = 4'b0000;
    wait_idle("tag_idle");
    check("tag_count", 32'(q.size() - base), 32'd4);
    for (int g = 0; g < 4; g++)
      chk_rec("tag", base, g, 2'(g), res_tab[g], t0 + g + 10, (g >= 2) ? TAG_EN : 1'b0);
    check("tag_sticky", 32'(tag_err), 32'(TAG_EN));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
